// File: rtl/add_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package add_seq_pkg;

   // Width of the shared adder slice.
   localparam int NIBBLE_W = 4;

   // Sequencer states.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Width of the nibble index counter.
   function automatic int idx_width(input int nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage : add_seq_pkg

// File: rtl/add_seq_ctrl_if.sv
// Request/response bundle between a requesting datapath and add_seq_ctrl.
// Handshake: start is sampled only in a cycle where ready=1, and a, b, sub
// are captured at that same edge. busy is the inverse of ready. done pulses
// for exactly one cycle when result, c_out and ovf take their final value;
// those outputs then hold until the next completion. There is no
// backpressure on the result side.
interface add_seq_ctrl_if #(
   parameter int NIBBLES = 4
) ();
   localparam int W = add_seq_pkg::NIBBLE_W * NIBBLES;

   logic                  start;
   logic                  sub;
   logic [W-1:0]          a;
   logic [W-1:0]          b;
   logic                  ready;
   logic                  busy;
   logic                  done;
   logic [W-1:0]          result;
   logic                  c_out;
   logic                  ovf;
   add_seq_pkg::state_t   state;

   // Requesting side.
   modport master (
      output start, sub, a, b,
      input  ready, busy, done, result, c_out, ovf, state
   );

   // Sequencer side.
   modport slave (
      input  start, sub, a, b,
      output ready, busy, done, result, c_out, ovf, state
   );

endinterface : add_seq_ctrl_if

// File: rtl/add2comp.sv
// 4-bit two's-complement adder slice, purely combinational.
module add2comp (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       c_in,
   output logic [3:0] sum,
   output logic       c_out
);

   // One 5-bit add gives both the sum nibble and the carry out.
   assign {c_out, sum} = {1'b0, x} + {1'b0, y} + {4'b0000, c_in};

endmodule : add2comp

// File: rtl/add_seq_ctrl.sv
// Wide signed add/subtract performed one nibble per clock on a single
// shared 4-bit adder slice, with carry chaining and signed-overflow flag.
module add_seq_ctrl #(
   parameter int NIBBLES = 4
) (
   input logic          clk,
   input logic          rst,
   add_seq_ctrl_if.slave bus
);
   import add_seq_pkg::*;

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = idx_width(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t               state_q;
   state_t               state_d;
   logic [IDX_W-1:0]     idx_q;
   logic [W-1:0]         a_q;
   logic [W-1:0]         b_q;
   logic                 sub_q;
   logic                 carry_q;
   logic [W-1:0]         acc_q;
   logic [W-1:0]         result_q;
   logic                 c_out_q;
   logic                 ovf_q;
   logic                 done_q;

   logic [NIBBLE_W-1:0]  slice_x;
   logic [NIBBLE_W-1:0]  slice_b;
   logic [NIBBLE_W-1:0]  slice_y;
   logic [NIBBLE_W-1:0]  slice_sum;
   logic                 slice_c_out;
   logic                 accept;
   logic                 last_step;
   logic                 ready_c;

   assign accept    = (state_q == IDLE) && bus.start;
   assign last_step = (state_q == RUN) && (idx_q == LAST_IDX);

   // Select the current nibble of each operand; B is inverted for subtract
   // and the carry register was preloaded with sub, giving A + ~B + 1.
   always_comb begin
      slice_x = '0;
      slice_b = '0;
      for (int k = 0; k < NIBBLES; k++) begin
         if (idx_q == IDX_W'(k)) begin
            slice_x = a_q[k*NIBBLE_W +: NIBBLE_W];
            slice_b = b_q[k*NIBBLE_W +: NIBBLE_W];
         end
      end
      slice_y = slice_b ^ {NIBBLE_W{sub_q}};
   end

   add2comp u_slice (
      .x     (slice_x),
      .y     (slice_y),
      .c_in  (carry_q),
      .sum   (slice_sum),
      .c_out (slice_c_out)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: one RUN pass per nibble, back to IDLE after the last.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (idx_q == LAST_IDX) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM-derived outputs.
   always_comb begin
      ready_c = (state_q == IDLE);
   end

   // Operand capture, nibble stepping and carry chaining.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         acc_q   <= '0;
      end else if (accept) begin
         idx_q   <= '0;
         a_q     <= bus.a;
         b_q     <= bus.b;
         sub_q   <= bus.sub;
         carry_q <= bus.sub;
      end else if (state_q == RUN) begin
         for (int k = 0; k < NIBBLES; k++) begin
            if (idx_q == IDX_W'(k)) begin
               acc_q[k*NIBBLE_W +: NIBBLE_W] <= slice_sum;
            end
         end
         carry_q <= slice_c_out;
         idx_q   <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
   end

   // Result and flags update only at the completion edge; done pulses once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         c_out_q  <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= last_step;
         if (last_step) begin
            result_q <= {slice_sum, acc_q[W-NIBBLE_W-1:0]};
            c_out_q  <= slice_c_out;
            // Overflow: operands of equal sign produce a sum of the other sign.
            ovf_q    <= (a_q[W-1] == slice_y[NIBBLE_W-1]) &&
                        (slice_sum[NIBBLE_W-1] != a_q[W-1]);
         end
      end
   end

   assign bus.ready  = ready_c;
   assign bus.busy   = ~ready_c;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.c_out  = c_out_q;
   assign bus.ovf    = ovf_q;
   assign bus.state  = state_q;

endmodule : add_seq_ctrl

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl with NIBBLES=4.
module tb_add_seq_ctrl;
   import add_seq_pkg::*;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic clk;
   logic rst;

   int n_checks;
   int n_bad;

   logic [W-1:0] exp_q[$];

   add_seq_ctrl_if #(.NIBBLES(NIB)) bus ();

   add_seq_ctrl #(.NIBBLES(NIB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Clock and reset.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present a request at the next falling edge; returns #1 after the
   // accepting rising edge with start dropped.
   task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      @(negedge clk);
      bus.a     = a;
      bus.b     = b;
      bus.sub   = sub;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Wait (bounded) for done, sampling #1 after each rising edge; returns the
   // number of edges waited, or 99 on timeout. Ends inside the done cycle.
   task automatic wait_done(output int lat);
      int n;
      n = 0;
      while (bus.done !== 1'b1 && n < 12) begin
         @(posedge clk);
         #1;
         n++;
      end
      lat = (bus.done === 1'b1) ? n : 99;
   endtask

   task automatic check_result(input string tag, input logic c, input logic o);
      logic [W-1:0] exp_r;
      if (exp_q.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 1, 0);
      end else begin
         exp_r = exp_q.pop_front();
         check({tag, "_result"}, 32'(bus.result), 32'(exp_r));
      end
      check({tag, "_c_out"}, 32'(bus.c_out), 32'(c));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(o));
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic [W-1:0] exp_r,
                         input logic c, input logic o);
      int lat;
      exp_q.push_back(exp_r);
      drive_start(a, b, sub);
      check({tag, "_busy"}, 32'(bus.busy), 1);
      wait_done(lat);
      check({tag, "_latency"}, lat, NIB);
      check_result(tag, c, o);
      @(posedge clk);
      #1;
      check({tag, "_done_one_cycle"}, 32'(bus.done), 0);
   endtask

   initial begin
      int  lat;
      logic saw_done;
      n_checks  = 0;
      n_bad     = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready",  32'(bus.ready),  1);
      check("rst_busy",   32'(bus.busy),   0);
      check("rst_done",   32'(bus.done),   0);
      check("rst_result", 32'(bus.result), 0);
      check("rst_state",  32'(bus.state),  32'(IDLE));
      @(negedge clk);
      rst = 1'b0;

      // Basic arithmetic vectors.
      run_op("add_plain", 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
      run_op("add_povf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("sub_borrow",16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op("sub_novf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // Start while busy is ignored; start in the done cycle is accepted.
      exp_q.push_back(16'h2201);
      drive_start(16'h1234, 16'h0FCD, 1'b0);
      @(negedge clk);
      bus.a     = 16'h7FFF;
      bus.b     = 16'h0001;
      bus.sub   = 1'b1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("hs_result_held", 32'(bus.result), 32'h7FFF);
      wait_done(lat);
      check("hs_latency", lat, NIB - 1);
      check_result("hs_first", 1'b0, 1'b0);
      // Still inside the done cycle: present the next request right away.
      check("hs_ready_in_done", 32'(bus.ready), 1);
      exp_q.push_back(16'h0000);
      bus.a     = 16'hFFFF;
      bus.b     = 16'h0001;
      bus.sub   = 1'b0;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("b2b_busy", 32'(bus.busy), 1);
      check("b2b_done_dropped", 32'(bus.done), 0);
      wait_done(lat);
      check("b2b_latency", lat, NIB);
      check_result("b2b", 1'b1, 1'b0);

      // Reset in the second RUN cycle discards the operation.
      @(posedge clk);
      #1;
      drive_start(16'h1111, 16'h2222, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_ready",  32'(bus.ready),  1);
      check("mid_rst_busy",   32'(bus.busy),   0);
      check("mid_rst_result", 32'(bus.result), 0);
      check("mid_rst_c_out",  32'(bus.c_out),  0);
      check("mid_rst_ovf",    32'(bus.ovf),    0);
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) saw_done = 1'b1;
      end
      check("mid_rst_no_done", 32'(saw_done), 0);
      run_op("after_rst", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_add_seq_ctrl

// File: doc/add_seq_ctrl.md
# add_seq_ctrl

Multi-cycle sequencer that reuses one 4-bit two's-complement adder slice to perform wide signed add/subtract, one nibble per clock. It sits between a requesting datapath (start/done handshake) and a single `add2comp` instance. It owns operand capture, nibble selection, carry chaining, subtract inversion, and signed-overflow detection, so that wide arithmetic costs one 4-bit adder instead of a full-width one.

## Interface

**Parameters**
- `NIBBLES`, default 4: operand width in nibbles; W = 4*NIBBLES. Legal range 2..16.

**Ports**
- `clk`: input, 1. Single clock; all state updates on the rising edge.
- `rst`: input, 1. Asynchronous, active-high reset.
- `start`: input, 1. Request pulse; sampled only while `ready`=1.
- `sub`: input, 1. 0 = a+b, 1 = a−b; captured with `start`.
- `a`: input, W. Signed operand A; captured with `start`.
- `b`: input, W. Signed operand B; captured with `start`.
- `ready`: output, 1. Idle and able to accept `start`.
- `busy`: output, 1. Operation in progress (equals ~`ready`).
- `done`: output, 1. One-cycle pulse; result and flags final.
- `result`: output, W. Wide sum or difference, two's complement.
- `c_out`: output, 1. Carry out of the MSB nibble. For subtract, 1 means no borrow.
- `ovf`: output, 1. Signed overflow of the W-bit operation.

## Operation

- FSM has two states:
  - `IDLE`: `ready`=1.
  - `RUN`: `busy`=1. Nibble index `idx` counts 0..NIBBLES−1.
- `IDLE` → `RUN` on `start`=1. At that edge:
  - capture `a`, `b`, `sub`;
  - set `idx`=0;
  - carry register = `sub`.
- Every `RUN` cycle drives the adder slice:
  - x = A[4·idx+3 : 4·idx];
  - y = B[4·idx+3 : 4·idx] XOR {4{sub}};
  - c_in = carry register.
- At the following edge, during `RUN`:
  - the slice sum is stored into accumulator nibble `idx`;
  - carry register = slice c_out;
  - `idx` increments.
- `RUN` → `IDLE` at the edge that stores nibble NIBBLES−1. At that same edge:
  - `result` = accumulator including the final nibble;
  - `c_out` = final slice carry;
  - `ovf` = (A[W−1] == y_msb) && (sum_msb != A[W−1]), where y_msb is the inverted B MSB when `sub`=1;
  - `done` = 1 for exactly one cycle.
- `result`, `c_out` and `ovf` change only at the completion edge. They hold their value until the next completion.
- `start` while `busy` is ignored; no queuing. Operands are not re-sampled.
- `start` in the cycle where `done`=1 is accepted, because the state is already `IDLE`. This gives back-to-back operation with no bubble.
- Reset, asynchronous at any time including mid-`RUN`:
  - state = `IDLE`, `idx`=0;
  - accumulator, `result`, `c_out`, `ovf`, `done` = 0;
  - `ready`=1, `busy`=0.
- The interrupted operation is discarded and produces no `done`.

## Timing

- Edge E0 samples `start`=1. `busy` is high from after E0 through E(NIBBLES).
- Nibble k is computed in the cycle after edge E(k) and registered at edge E(k+1).
- `done` is high during the cycle following E(NIBBLES).
- Start-to-done latency is NIBBLES cycles. Throughput is one operation per NIBBLES cycles.
- The adder slice is purely combinational. There is one slice evaluation per cycle, and the critical path is through that one 4-bit slice.

## Structure

- Shared package `add_seq_pkg`:
  - `NIBBLE_W`=4;
  - state enum `{IDLE, RUN}`;
  - an index width helper, $clog2(NIBBLES).
- One sub-module: `add2comp`, the existing 4-bit two's-complement adder with ports `x[3:0]`, `y[3:0]`, `c_in`, `sum[3:0]`, `c_out`. It is instantiated once.
- All remaining logic is local: operand registers, accumulator, carry register, index counter, FSM and flag logic.

## Test plan

All scenarios use NIBBLES=4.

- Add, no overflow: a=0x1234, b=0x0FCD, sub=0 → `done` exactly 4 cycles after start; result=0x2201, c_out=0, ovf=0.
- Add, positive overflow: a=0x7FFF, b=0x0001, sub=0 → result=0x8000, c_out=0, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1 → result=0xFFFE, c_out=0, ovf=0.
- Subtract, negative overflow: a=0x8000, b=0x0001, sub=1 → result=0x7FFF, c_out=1, ovf=1.
- Handshake:
  - start pulse with new operands while busy → ignored, and the first result is unchanged;
  - start asserted during the `done` cycle (a=0xFFFF, b=0x0001, sub=0) → accepted; result=0x0000, c_out=1, ovf=0 after 4 more cycles.
- Reset mid-operation: assert `rst` in the 2nd `RUN` cycle → immediately `ready`=1, `busy`=0, result=0, flags=0; no `done` pulse. A subsequent start computes correctly.
